// File: rtl/axi4lite_cmd_master.sv
// ============================================================================
// Module : axi4lite_cmd_master
// Brief  : Runs one AXI4-Lite read or write per request-channel command and
//          returns the result on a response channel; counts completions.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module axi4lite_cmd_master #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                      CLK,
  input  logic                      RSTn,
  // command channel
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
  // response channel
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_write,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                rsp_resp,
  // AXI4-Lite master port
  output logic [ADDR_WIDTH-1:0]     AWADDR,
  output logic                      AWVALID,
  input  logic                      AWREADY,
  output logic [DATA_WIDTH-1:0]     WDATA,
  output logic [DATA_WIDTH/8-1:0]   WSTRB,
  output logic                      WVALID,
  input  logic                      WREADY,
  input  logic [1:0]                BRESP,
  input  logic                      BVALID,
  output logic                      BREADY,
  output logic [ADDR_WIDTH-1:0]     ARADDR,
  output logic                      ARVALID,
  input  logic                      ARREADY,
  input  logic [DATA_WIDTH-1:0]     RDATA,
  input  logic [1:0]                RRESP,
  input  logic                      RVALID,
  output logic                      RREADY,
  // debug counters
  output logic [CNT_WIDTH-1:0]      wr_count,
  output logic [CNT_WIDTH-1:0]      rd_count
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_RSP     = 3'd5
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;

  logic                      r_cmd_ready;
  logic [ADDR_WIDTH-1:0]     r_awaddr;
  logic                      r_awvalid;
  logic [DATA_WIDTH-1:0]     r_wdata;
  logic [DATA_WIDTH/8-1:0]   r_wstrb;
  logic                      r_wvalid;
  logic                      r_aw_done;
  logic                      r_w_done;
  logic                      r_bready;
  logic [ADDR_WIDTH-1:0]     r_araddr;
  logic                      r_arvalid;
  logic                      r_rready;
  logic                      r_rsp_valid;
  logic                      r_rsp_write;
  logic [DATA_WIDTH-1:0]     r_rsp_rdata;
  logic [1:0]                r_rsp_resp;
  logic [CNT_WIDTH-1:0]      r_wr_count;
  logic [CNT_WIDTH-1:0]      r_rd_count;

  logic w_cmd_fire;
  logic w_aw_fire;
  logic w_w_fire;
  logic w_b_fire;
  logic w_ar_fire;
  logic w_r_fire;
  logic w_rsp_fire;
  logic w_aw_done;
  logic w_w_done;

  assign w_cmd_fire = cmd_valid   & r_cmd_ready;
  assign w_aw_fire  = r_awvalid   & AWREADY;
  assign w_w_fire   = r_wvalid    & WREADY;
  assign w_b_fire   = r_bready    & BVALID;
  assign w_ar_fire  = r_arvalid   & ARREADY;
  assign w_r_fire   = r_rready    & RVALID;
  assign w_rsp_fire = r_rsp_valid & rsp_ready;

  // AW and W may complete in either order or together
  assign w_aw_done  = r_aw_done | w_aw_fire;
  assign w_w_done   = r_w_done  | w_w_fire;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_cmd_fire) w_state_nxt = cmd_write ? ST_WR_REQ : ST_RD_ADDR;
      ST_WR_REQ:  if (w_aw_done && w_w_done) w_state_nxt = ST_WR_RESP;
      ST_WR_RESP: if (w_b_fire) w_state_nxt = ST_RSP;
      ST_RD_ADDR: if (w_ar_fire) w_state_nxt = ST_RD_DATA;
      ST_RD_DATA: if (w_r_fire) w_state_nxt = ST_RSP;
      ST_RSP:     if (w_rsp_fire) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_cmd_ready <= 1'b0;
      r_awaddr    <= '0;
      r_awvalid   <= 1'b0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_wvalid    <= 1'b0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_bready    <= 1'b0;
      r_araddr    <= '0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= 2'b00;
      r_wr_count  <= '0;
      r_rd_count  <= '0;
    end else begin
      // registered so cmd_ready stays low through reset and the first cycle after
      r_cmd_ready <= (w_state_nxt == ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          if (w_cmd_fire) begin
            if (cmd_write) begin
              r_awaddr  <= cmd_addr;
              r_wdata   <= cmd_wdata;
              r_wstrb   <= cmd_wstrb;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_aw_done <= 1'b0;
              r_w_done  <= 1'b0;
            end else begin
              r_araddr  <= cmd_addr;
              r_arvalid <= 1'b1;
            end
          end
        end
        ST_WR_REQ: begin
          if (w_aw_fire) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_fire) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
          end
        end
        ST_WR_RESP: begin
          if (w_b_fire) begin
            r_bready    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_write <= 1'b1;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= BRESP;
            r_wr_count  <= r_wr_count + CNT_WIDTH'(1);
          end
        end
        ST_RD_ADDR: begin
          if (w_ar_fire) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
          end
        end
        ST_RD_DATA: begin
          if (w_r_fire) begin
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= RDATA;
            r_rsp_resp  <= RRESP;
            r_rd_count  <= r_rd_count + CNT_WIDTH'(1);
          end
        end
        ST_RSP: begin
          if (w_rsp_fire) begin
            r_rsp_valid <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_write = r_rsp_write;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_resp  = r_rsp_resp;
  assign AWADDR    = r_awaddr;
  assign AWVALID   = r_awvalid;
  assign WDATA     = r_wdata;
  assign WSTRB     = r_wstrb;
  assign WVALID    = r_wvalid;
  assign BREADY    = r_bready;
  assign ARADDR    = r_araddr;
  assign ARVALID   = r_arvalid;
  assign RREADY    = r_rready;
  assign wr_count  = r_wr_count;
  assign rd_count  = r_rd_count;

endmodule

`default_nettype wire

// File: tb/tb_axi4lite_cmd_master.sv
// ============================================================================
// Module : tb_axi4lite_cmd_master
// Brief  : Bench for axi4lite_cmd_master with a stallable memory slave model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_axi4lite_cmd_master;
  localparam int AW = 6;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int CW = 2;

  logic CLK = 1'b0;
  logic RSTn = 1'b1;
  always #5 CLK = ~CLK;

  logic cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [SW-1:0] cmd_wstrb = '0;
  logic cmd_ready, rsp_valid, rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic [1:0] rsp_resp;
  logic [AW-1:0] AWADDR, ARADDR;
  logic AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY, ARVALID, ARREADY, RVALID, RREADY;
  logic [DW-1:0] WDATA, RDATA;
  logic [SW-1:0] WSTRB;
  logic [1:0] BRESP, RRESP;
  logic [CW-1:0] wr_count, rd_count;

  axi4lite_cmd_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .wr_count(wr_count), .rd_count(rd_count)
  );

  int total = 0;
  int bad = 0;

  // slave knobs: ready delay per channel and response codes
  int aw_dly = 0, w_dly = 0, ar_dly = 0;
  logic [1:0] slv_bresp = 2'b00, slv_rresp = 2'b00;

  // reference model: expected memory and completion counts
  logic [31:0] ref_mem [16];
  int wr_n = 0, rd_n = 0;

  // ---------------- slave model ----------------
  int aw_cyc, w_cyc, ar_cyc;
  logic [31:0] dev_mem [16];
  logic aw_seen, w_seen;
  logic [5:0] aw_a;
  logic [31:0] w_d;
  logic [3:0] w_s;

  assign AWREADY = AWVALID && (aw_cyc >= aw_dly);
  assign WREADY  = WVALID  && (w_cyc  >= w_dly);
  assign ARREADY = ARVALID && (ar_cyc >= ar_dly);

  always @(posedge CLK or negedge RSTn) begin : slave
    logic [5:0] a;
    logic [31:0] d, nw;
    logic [3:0] s;
    if (!RSTn) begin
      aw_cyc <= 0; w_cyc <= 0; ar_cyc <= 0;
      aw_seen <= 1'b0; w_seen <= 1'b0; aw_a <= '0; w_d <= '0; w_s <= '0;
      BVALID <= 1'b0; BRESP <= 2'b00; RVALID <= 1'b0; RDATA <= '0; RRESP <= 2'b00;
      for (int i = 0; i < 16; i++) dev_mem[i] <= '0;
    end else begin
      aw_cyc <= (AWVALID && !AWREADY) ? aw_cyc + 1 : 0;
      w_cyc  <= (WVALID && !WREADY) ? w_cyc + 1 : 0;
      ar_cyc <= (ARVALID && !ARREADY) ? ar_cyc + 1 : 0;
      a = aw_seen ? aw_a : AWADDR;
      d = w_seen ? w_d : WDATA;
      s = w_seen ? w_s : WSTRB;
      if (BVALID && BREADY) BVALID <= 1'b0;
      if (RVALID && RREADY) RVALID <= 1'b0;
      if ((aw_seen || (AWVALID && AWREADY)) && (w_seen || (WVALID && WREADY))) begin
        nw = dev_mem[a[5:2]];
        for (int b = 0; b < 4; b++) if (s[b]) nw[8*b +: 8] = d[8*b +: 8];
        dev_mem[a[5:2]] <= nw;
        BVALID <= 1'b1; BRESP <= slv_bresp;
        aw_seen <= 1'b0; w_seen <= 1'b0;
      end else begin
        if (AWVALID && AWREADY) begin aw_seen <= 1'b1; aw_a <= AWADDR; end
        if (WVALID && WREADY) begin w_seen <= 1'b1; w_d <= WDATA; w_s <= WSTRB; end
      end
      if (ARVALID && ARREADY) begin
        RVALID <= 1'b1; RDATA <= dev_mem[ARADDR[5:2]]; RRESP <= slv_rresp;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic model_write(input int idx, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++) if (s[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    wr_n = 0; rd_n = 0;
  endtask

  task automatic apply_reset();
    RSTn = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RSTn = 1'b1;
    model_clear();
    @(posedge CLK); #1;
  endtask

  // issues one command, waits for and consumes its response; lat counts from acceptance
  task automatic do_cmd(input bit wr, input int idx, input logic [31:0] d, input logic [3:0] s,
                        output logic rw, output logic [31:0] rdata, output logic [1:0] resp,
                        output int lat);
    int n;
    rw = 1'b0; rdata = '0; resp = 2'b00; lat = -1;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = AW'(idx * 4); cmd_wdata = d; cmd_wstrb = s;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 100) begin @(posedge CLK); #1; n++; end
    if (n >= 100) begin
      total++; bad++;
      $display("FAIL cmd_accept timeout: cmd_ready=%b required 1", cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge CLK); #1;
    cmd_valid = 1'b0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 200) begin @(posedge CLK); #1; lat++; end
    if (lat >= 200) begin
      total++; bad++;
      $display("FAIL rsp timeout: rsp_valid=%b required 1", rsp_valid);
      return;
    end
    rw = rsp_write; rdata = rsp_rdata; resp = rsp_resp;
    if (wr) begin model_write(idx, d, s); wr_n++; end
    else rd_n++;
    rsp_ready = 1'b1;
    @(posedge CLK); #1;
    rsp_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1 RSTn = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    total++;
    if (cmd_ready !== 1'b0) begin bad++; $display("FAIL reset_cmd_ready: got %b required 0", cmd_ready); end
    total++;
    if ({AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid} !== 6'b0) begin
      bad++; $display("FAIL reset_handshake: got %b required 000000",
                      {AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid});
    end
    total++;
    if ({wr_count, rd_count, rsp_write, rsp_resp, rsp_rdata} !== '0) begin
      bad++; $display("FAIL reset_outputs: wr=%0d rd=%0d rdata=%h required all 0", wr_count, rd_count, rsp_rdata);
    end
    RSTn = 1'b1;
    model_clear();
    @(posedge CLK); #1;
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready: got %b required 1", cmd_ready); end
  endtask

  task automatic test_basic();
    logic rw; logic [31:0] rd; logic [1:0] rs; int lat;
    do_cmd(1'b1, 2, 32'hDEADBEEF, 4'hF, rw, rd, rs, lat);
    total++;
    if ({rw, rs, rd} !== {1'b1, 2'b00, 32'h0}) begin
      bad++; $display("FAIL basic_write_rsp: got w=%b resp=%b rdata=%h required 1 00 0", rw, rs, rd);
    end
    total++;
    if (wr_count !== CW'(wr_n % (1 << CW)) || lat != 3) begin
      bad++; $display("FAIL basic_write_cnt_lat: got cnt=%0d lat=%0d required %0d 3", wr_count, lat, wr_n % (1 << CW));
    end
    do_cmd(1'b0, 2, 32'h0, 4'h0, rw, rd, rs, lat);
    total++;
    if ({rw, rs, rd} !== {1'b0, 2'b00, 32'hDEADBEEF}) begin
      bad++; $display("FAIL basic_read_rsp: got w=%b resp=%b rdata=%h required 0 00 deadbeef", rw, rs, rd);
    end
    total++;
    if (rd_count !== CW'(rd_n % (1 << CW)) || lat != 3) begin
      bad++; $display("FAIL basic_read_cnt_lat: got cnt=%0d lat=%0d required %0d 3", rd_count, lat, rd_n % (1 << CW));
    end
  endtask

  task automatic test_partial_strobe();
    logic rw; logic [31:0] rd; logic [1:0] rs; int lat;
    do_cmd(1'b1, 4, 32'hFFFFFFFF, 4'hF, rw, rd, rs, lat);
    do_cmd(1'b1, 4, 32'h00000000, 4'h5, rw, rd, rs, lat);
    do_cmd(1'b0, 4, 32'h0, 4'h0, rw, rd, rs, lat);
    total++;
    if (rd !== 32'hFF00FF00 || rd !== ref_mem[4]) begin
      bad++; $display("FAIL partial_strobe: got %h required ff00ff00", rd);
    end
  endtask

  task automatic test_stall();
    for (int r = 0; r < 2; r++) begin
      int idx, n, m, rsp_k, aw_bad, w_bad, b_bad, b_hs;
      logic [31:0] d; logic [3:0] s;
      idx = $urandom_range(0, 15); d = $urandom; s = 4'($urandom_range(1, 15));
      aw_dly = (r == 0) ? 4 : 0; w_dly = (r == 0) ? 0 : 4; slv_bresp = 2'b10;
      m = ((aw_dly > w_dly) ? aw_dly : w_dly) + 1;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = AW'(idx * 4); cmd_wdata = d; cmd_wstrb = s;
      n = 0;
      while (cmd_ready !== 1'b1 && n < 50) begin @(posedge CLK); #1; n++; end
      @(posedge CLK); #1;
      cmd_valid = 1'b0; cmd_wdata = '0; cmd_addr = '0;
      aw_bad = 0; w_bad = 0; b_bad = 0; b_hs = 0; rsp_k = 0;
      for (int k = 1; k <= 40 && rsp_k == 0; k++) begin
        if (AWVALID !== (k <= aw_dly + 1)) aw_bad++;
        if (AWVALID === 1'b1 && AWADDR !== AW'(idx * 4)) aw_bad++;
        if (WVALID !== (k <= w_dly + 1)) w_bad++;
        if (WVALID === 1'b1 && (WDATA !== d || WSTRB !== s)) w_bad++;
        if (BREADY !== (k == m + 1)) b_bad++;
        if (BVALID === 1'b1 && BREADY === 1'b1) b_hs++;
        if (rsp_valid === 1'b1) rsp_k = k;
        else begin @(posedge CLK); #1; end
      end
      total++;
      if (aw_bad != 0 || w_bad != 0) begin
        bad++; $display("FAIL stall%0d_valid_payload: got aw_bad=%0d w_bad=%0d required 0 0", r, aw_bad, w_bad);
      end
      total++;
      if (b_bad != 0 || b_hs != 1) begin
        bad++; $display("FAIL stall%0d_bchan: got b_bad=%0d b_hs=%0d required 0 1", r, b_bad, b_hs);
      end
      model_write(idx, d, s); wr_n++;
      total++;
      if (rsp_k != m + 2 || rsp_resp !== 2'b10 || wr_count !== CW'(wr_n % (1 << CW))) begin
        bad++; $display("FAIL stall%0d_rsp: got k=%0d resp=%b cnt=%0d required %0d 10 %0d",
                        r, rsp_k, rsp_resp, wr_count, m + 2, wr_n % (1 << CW));
      end
      rsp_ready = 1'b1; @(posedge CLK); #1; rsp_ready = 1'b0;
    end
    aw_dly = 0; w_dly = 0; slv_bresp = 2'b00;
  endtask

  task automatic test_rsp_hold();
    int idx, idx2, n, stab_bad;
    logic [31:0] r0;
    idx = $urandom_range(0, 15); idx2 = (idx + 5) % 16;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = AW'(idx * 4);
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin @(posedge CLK); #1; n++; end
    @(posedge CLK); #1;
    cmd_valid = 1'b0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 50) begin @(posedge CLK); #1; n++; end
    rd_n++;
    r0 = rsp_rdata;
    total++;
    if (r0 !== ref_mem[idx]) begin bad++; $display("FAIL hold_first_rdata: got %h required %h", r0, ref_mem[idx]); end
    cmd_valid = 1'b1; cmd_addr = AW'(idx2 * 4);
    stab_bad = 0;
    repeat (5) begin
      @(posedge CLK); #1;
      if (rsp_valid !== 1'b1 || rsp_rdata !== r0 || cmd_ready !== 1'b0 || ARVALID !== 1'b0) stab_bad++;
    end
    total++;
    if (stab_bad != 0) begin bad++; $display("FAIL hold_stable: got %0d unstable cycles required 0", stab_bad); end
    rsp_ready = 1'b1; @(posedge CLK); #1; rsp_ready = 1'b0;
    total++;
    if (cmd_ready !== 1'b1 || ARVALID !== 1'b0 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL hold_gap: got ready=%b arvalid=%b rsp_valid=%b required 1 0 0", cmd_ready, ARVALID, rsp_valid);
    end
    @(posedge CLK); #1;
    cmd_valid = 1'b0;
    total++;
    if (cmd_ready !== 1'b0 || ARVALID !== 1'b1 || ARADDR !== AW'(idx2 * 4)) begin
      bad++; $display("FAIL hold_accept: got ready=%b arvalid=%b araddr=%h required 0 1 %h",
                      cmd_ready, ARVALID, ARADDR, AW'(idx2 * 4));
    end
    n = 0;
    while (rsp_valid !== 1'b1 && n < 50) begin @(posedge CLK); #1; n++; end
    rd_n++;
    total++;
    if (rsp_rdata !== ref_mem[idx2] || rd_count !== CW'(rd_n % (1 << CW))) begin
      bad++; $display("FAIL hold_second: got rdata=%h cnt=%0d required %h %0d",
                      rsp_rdata, rd_count, ref_mem[idx2], rd_n % (1 << CW));
    end
    rsp_ready = 1'b1; @(posedge CLK); #1; rsp_ready = 1'b0;
  endtask

  task automatic test_random();
    logic rw; logic [31:0] rd, d, exp_d; logic [1:0] rs, exp_r; logic [3:0] s;
    int lat, exp_lat, idx; bit wr;
    for (int i = 0; i < 30; i++) begin
      wr = 1'($urandom_range(0, 1)); idx = $urandom_range(0, 15);
      d = $urandom; s = 4'($urandom_range(0, 15));
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); ar_dly = $urandom_range(0, 3);
      slv_bresp = 2'($urandom_range(0, 3)); slv_rresp = 2'($urandom_range(0, 3));
      exp_d = wr ? 32'h0 : ref_mem[idx];
      exp_r = wr ? slv_bresp : slv_rresp;
      exp_lat = wr ? ((aw_dly > w_dly) ? aw_dly : w_dly) + 3 : ar_dly + 3;
      do_cmd(wr, idx, d, s, rw, rd, rs, lat);
      total++;
      if ({rw, rs, rd} !== {wr, exp_r, exp_d}) begin
        bad++; $display("FAIL rand%0d_rsp: got w=%b resp=%b rdata=%h required %b %b %h", i, rw, rs, rd, wr, exp_r, exp_d);
      end
      total++;
      if (lat != exp_lat) begin bad++; $display("FAIL rand%0d_latency: got %0d required %0d", i, lat, exp_lat); end
      total++;
      if (wr_count !== CW'(wr_n % (1 << CW)) || rd_count !== CW'(rd_n % (1 << CW))) begin
        bad++; $display("FAIL rand%0d_counts: got wr=%0d rd=%0d required %0d %0d",
                        i, wr_count, rd_count, wr_n % (1 << CW), rd_n % (1 << CW));
      end
    end
    aw_dly = 0; w_dly = 0; ar_dly = 0; slv_bresp = 2'b00; slv_rresp = 2'b00;
  endtask

  task automatic test_reset_mid();
    logic rw; logic [31:0] rd; logic [1:0] rs; int lat, n;
    aw_dly = 4;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = AW'(12); cmd_wdata = 32'h12345678; cmd_wstrb = 4'hF;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin @(posedge CLK); #1; n++; end
    @(posedge CLK); #1;
    cmd_valid = 1'b0;
    total++;
    if (AWVALID !== 1'b1) begin bad++; $display("FAIL midrst_pre: got awvalid=%b required 1", AWVALID); end
    RSTn = 1'b0;
    #1;
    total++;
    if ({AWVALID, WVALID, BREADY, rsp_valid, cmd_ready} !== 5'b0 || wr_count !== '0) begin
      bad++; $display("FAIL midrst_clear: got aw=%b w=%b b=%b rv=%b rdy=%b cnt=%0d required all 0",
                      AWVALID, WVALID, BREADY, rsp_valid, cmd_ready, wr_count);
    end
    aw_dly = 0;
    @(posedge CLK); #1;
    RSTn = 1'b1;
    model_clear();
    @(posedge CLK); #1;
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready: got %b required 1", cmd_ready); end
    do_cmd(1'b0, 0, 32'h0, 4'h0, rw, rd, rs, lat);
    total++;
    if (rs !== 2'b00 || rd !== ref_mem[0] || rd_count !== CW'(rd_n % (1 << CW)) || wr_count !== '0) begin
      bad++; $display("FAIL midrst_read: got resp=%b rdata=%h rd=%0d wr=%0d required 00 %h %0d 0",
                      rs, rd, rd_count, wr_count, ref_mem[0], rd_n % (1 << CW));
    end
  endtask

  task automatic test_wrap();
    logic rw; logic [31:0] rd; logic [1:0] rs; int lat;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      do_cmd(1'b0, $urandom_range(0, 15), 32'h0, 4'h0, rw, rd, rs, lat);
      total++;
      if (rd_count !== CW'(rd_n % (1 << CW)) || wr_count !== '0) begin
        bad++; $display("FAIL wrap%0d: got rd=%0d wr=%0d required %0d 0", i, rd_count, wr_count, rd_n % (1 << CW));
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_basic();
    test_partial_strobe();
    test_stall();
    test_rsp_hold();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/axi4lite_cmd_master.md
Name: axi4lite_cmd_master

Overview:
Command-driven AXI4-Lite master that sits directly upstream of slave_mem_axi4lite and drives its AXI4-Lite slave port. It accepts single read/write commands over a simple valid/ready request channel and runs exactly one AXI4-Lite transaction per command. It returns read data and response on a valid/ready response channel. It also keeps completed-transaction counters for bring-up and debug.

Parameters:
ADDR_WIDTH, 6, byte address width; matches the slave memory.
DATA_WIDTH, 32, data width; must be 32 or 64.
CNT_WIDTH, 16, width of each transaction counter.

Ports:
CLK  input  1  clock
RSTn  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  command accepted when high with cmd_valid
cmd_write  input  1  1 = write, 0 = read
cmd_addr  input  ADDR_WIDTH  byte address
cmd_wdata  input  DATA_WIDTH  write data
cmd_wstrb  input  DATA_WIDTH/8  write byte strobes
rsp_valid  output  1  response available
rsp_ready  input  1  response consumed when high with rsp_valid
rsp_write  output  1  response belongs to a write
rsp_rdata  output  DATA_WIDTH  read data; 0 for writes
rsp_resp  output  2  BRESP or RRESP as returned
AWADDR  output  ADDR_WIDTH
AWVALID  output  1
AWREADY  input  1
WDATA  output  DATA_WIDTH
WSTRB  output  DATA_WIDTH/8
WVALID  output  1
WREADY  input  1
BRESP  input  2
BVALID  input  1
BREADY  output  1
ARADDR  output  ADDR_WIDTH
ARVALID  output  1
ARREADY  input  1
RDATA  input  DATA_WIDTH
RRESP  input  2
RVALID  input  1
RREADY  output  1
wr_count  output  CNT_WIDTH  completed writes, wraps at 2^CNT_WIDTH
rd_count  output  CNT_WIDTH  completed reads, wraps at 2^CNT_WIDTH

Behaviour:
- Reset (async assert, sync deassert by the parent):
  - All VALID, READY, rsp_* and count outputs are 0.
  - cmd_ready is 0 during reset.
  - State is IDLE.
- All AXI and rsp outputs come straight from flops; no combinational path from input to output.
- cmd_ready = 1 only in IDLE. Command fields are latched on cmd_valid && cmd_ready.
- State machine:
  - IDLE, write accepted -> WR_REQ. In the next cycle AWVALID and WVALID both assert, with latched AWADDR, WDATA and WSTRB.
  - IDLE, read accepted -> RD_ADDR. In the next cycle ARVALID asserts with ARADDR.
  - WR_REQ: AW and W are tracked by independent done flags.
    - AWVALID drops the cycle after AWVALID && AWREADY.
    - WVALID drops the cycle after WVALID && WREADY.
    - Both handshakes may occur in the same cycle or in either order.
    - When both are done -> WR_RESP, with BREADY = 1.
  - WR_RESP: on BVALID && BREADY, capture BRESP, set rsp_write = 1 and rsp_rdata = 0, BREADY -> 0, increment wr_count -> RSP.
  - RD_ADDR: on ARVALID && ARREADY, ARVALID -> 0, RREADY -> 1 -> RD_DATA.
  - RD_DATA: on RVALID && RREADY, capture RDATA and RRESP, set rsp_write = 0, RREADY -> 0, increment rd_count -> RSP.
  - RSP: rsp_valid = 1, with fields held stable until rsp_ready. On rsp_valid && rsp_ready -> IDLE (rsp_valid = 0, cmd_ready = 1 next cycle). Back-to-back commands are therefore separated by at least one IDLE cycle.
- Once asserted, VALIDs are never deasserted and payloads never change until the handshake completes.
- Non-OKAY responses are passed through unchanged and still count as completed.
- Minimum latency with a zero-wait slave, cmd accept to rsp_valid:
  - Write: 3 cycles (AW/W, B, RSP).
  - Read: 3 cycles (AR, R, RSP).
- Reset mid-transaction returns all outputs to reset values immediately. The in-flight command and response are discarded. The slave is reset by the same RSTn.
- Counters wrap from 2^CNT_WIDTH-1 to 0 with no saturation.

Test Plan:
1. Bench connects this block to slave_mem_axi4lite. Write addr 0x08, data 0xDEADBEEF, strb 0xF -> rsp_write = 1, rsp_resp = 00, rsp_rdata = 0, wr_count = 1. Then read 0x08 -> rsp_rdata = 0xDEADBEEF, rsp_resp = 00, rd_count = 1.
2. Partial strobe:
   - Write 0x10 = 0xFFFFFFFF (strb 0xF).
   - Then write 0x10 = 0x00000000 with strb 0x5.
   - Then read 0x10 -> 0xFF00FF00.
3. Stall test with a bench slave model:
   - Hold AWREADY low 4 cycles with WREADY high immediately.
   - Then repeat with WREADY delayed 4 cycles instead.
   - Required in both cases: each VALID stays high with a stable payload until its own handshake, drops the cycle after, and exactly one B is awaited.
   - Assert BRESP = 10 -> rsp_resp = 10, wr_count still increments.
4. Hold rsp_ready low 5 cycles after a read:
   - rsp_valid and rsp_rdata stay stable.
   - cmd_ready stays 0.
   - A cmd_valid held high during this time is not accepted until 1 cycle after the rsp handshake.
5. Assert RSTn low while in WR_REQ with AWVALID = 1 -> AWVALID, WVALID, BREADY, rsp_valid and wr_count are 0 immediately. After release, cmd_ready = 1 and a fresh read of 0x00 completes with resp 00.
6. With CNT_WIDTH = 2, run 5 reads -> rd_count sequence 1, 2, 3, 0, 1, and wr_count = 0 throughout.
